// File: rtl/dense_seq_ctrl.sv
// Address and strobe sequencer for a shared MAC evaluating a fully-connected layer one neuron at a time.
// Every feature of every neuron is walked and each finished neuron is offered on a valid/ready port.
module dense_seq_ctrl #(
  parameter int H          = 5,
  parameter int W          = 5,
  parameter int DEPTH      = 64,
  parameter int BIAS       = 128,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_LAT    = 1,
  localparam int NUMS      = H * W * DEPTH,
  localparam int IW        = (NUMS > 1) ? $clog2(NUMS) : 1,
  localparam int KW        = ((NUMS * BIAS) > 1) ? $clog2(NUMS * BIAS) : 1,
  localparam int BW        = (BIAS > 1) ? $clog2(BIAS) : 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [IW-1:0] in_addr_o,
  output logic [KW-1:0] k_addr_o,
  output logic [BW-1:0] b_addr_o,
  output logic          mac_clr_o,
  output logic          mac_en_o,
  output logic          bias_add_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [BW-1:0] out_idx_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_BADD  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [IW-1:0] IN_LAST    = IW'(NUMS - 1);
  localparam logic [BW-1:0] N_LAST     = BW'(BIAS - 1);
  localparam logic [2:0]    DRAIN_LAST = (ROM_LAT > 0) ? 3'(ROM_LAT - 1) : 3'd0;

  if (ROM_LAT < 0 || ROM_LAT > 4 || DATA_WIDTH < 1) begin : g_bad_param
    $error("dense_seq_ctrl: ROM_LAT must be 0..4 and DATA_WIDTH positive");
  end

  logic [2:0]    state_r, state_nxt_s;
  logic [IW-1:0] in_addr_r, in_addr_nxt_s;
  logic [KW-1:0] k_addr_r, k_addr_nxt_s;
  logic [BW-1:0] neuron_r, neuron_nxt_s;
  logic [2:0]    drain_r, drain_nxt_s;
  logic          busy_r, rd_en_r, bias_add_r, out_valid_r, done_r;
  logic          first_s;

  // Next-state and counter update logic for the layer walk.
  always_comb begin
    state_nxt_s   = state_r;
    in_addr_nxt_s = in_addr_r;
    k_addr_nxt_s  = k_addr_r;
    neuron_nxt_s  = neuron_r;
    drain_nxt_s   = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s   = ST_LOAD;
          in_addr_nxt_s = '0;
          k_addr_nxt_s  = '0;
          neuron_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // k_addr holds on the last feature so it never runs past NUMS*BIAS-1
        if (in_addr_r == IN_LAST) begin
          drain_nxt_s = 3'd0;
          state_nxt_s = (ROM_LAT == 0) ? ST_BADD : ST_DRAIN;
        end else begin
          in_addr_nxt_s = in_addr_r + IW'(1'b1);
          k_addr_nxt_s  = k_addr_r + KW'(1'b1);
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_nxt_s = ST_BADD;
        end else begin
          drain_nxt_s = drain_r + 3'd1;
        end
      end
      ST_BADD: begin
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) begin
          if (neuron_r == N_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s   = ST_LOAD;
            neuron_nxt_s  = neuron_r + BW'(1'b1);
            in_addr_nxt_s = '0;
            k_addr_nxt_s  = k_addr_r + KW'(1'b1);
          end
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and output strobes, all decoded from the next state so they leave on flops.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      in_addr_r   <= '0;
      k_addr_r    <= '0;
      neuron_r    <= '0;
      drain_r     <= 3'd0;
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      bias_add_r  <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_addr_r   <= in_addr_nxt_s;
      k_addr_r    <= k_addr_nxt_s;
      neuron_r    <= neuron_nxt_s;
      drain_r     <= drain_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      rd_en_r     <= (state_nxt_s == ST_LOAD);
      bias_add_r  <= (state_nxt_s == ST_BADD);
      out_valid_r <= (state_nxt_s == ST_OUT);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign first_s = rd_en_r & (in_addr_r == '0);

  if (ROM_LAT == 0) begin : g_no_lat
    assign mac_en_o  = rd_en_r;
    assign mac_clr_o = first_s;
  end else begin : g_lat
    logic [ROM_LAT-1:0] en_pipe_r;
    logic [ROM_LAT-1:0] clr_pipe_r;

    // Delay the read strobe and its first-feature tag by the memory latency.
    always_ff @(posedge clk) begin
      if (rst_i) begin
        en_pipe_r  <= '0;
        clr_pipe_r <= '0;
      end else begin
        en_pipe_r[0]  <= rd_en_r;
        clr_pipe_r[0] <= first_s;
        for (int i = 1; i < ROM_LAT; i++) begin
          en_pipe_r[i]  <= en_pipe_r[i-1];
          clr_pipe_r[i] <= clr_pipe_r[i-1];
        end
      end
    end

    assign mac_en_o  = en_pipe_r[ROM_LAT-1];
    assign mac_clr_o = clr_pipe_r[ROM_LAT-1];
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign rd_en_o     = rd_en_r;
  assign bias_add_o  = bias_add_r;
  assign out_valid_o = out_valid_r;
  assign in_addr_o   = in_addr_r;
  assign k_addr_o    = k_addr_r;
  assign b_addr_o    = neuron_r;
  assign out_idx_o   = neuron_r;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Directed bench for dense_seq_ctrl: NUMS=4, BIAS=3, one instance with ROM_LAT=1 and one with ROM_LAT=0.
// Both instances share the same stimulus; outputs are compared against hand-computed values.
module tb_dense_seq_ctrl;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic out_ready_i = 1'b1;

  // ROM_LAT=1 instance outputs
  logic busy1, done1, rd1, clr1, en1, badd1, ov1;
  logic [1:0] in1, b1, idx1;
  logic [3:0] k1;
  // ROM_LAT=0 instance outputs
  logic busy0, done0, rd0, clr0, en0, badd0, ov0;
  logic [1:0] in0, b0, idx0;
  logic [3:0] k0;

  logic [6:0] ctl1, ctl0;
  assign ctl1 = {busy1, rd1, en1, clr1, badd1, ov1, done1};
  assign ctl0 = {busy0, rd0, en0, clr0, badd0, ov0, done0};

  dense_seq_ctrl #(.H(1), .W(1), .DEPTH(4), .BIAS(3), .DATA_WIDTH(32), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy1), .done_o(done1),
    .rd_en_o(rd1), .in_addr_o(in1), .k_addr_o(k1), .b_addr_o(b1), .mac_clr_o(clr1),
    .mac_en_o(en1), .bias_add_o(badd1), .out_valid_o(ov1), .out_ready_i(out_ready_i),
    .out_idx_o(idx1)
  );

  dense_seq_ctrl #(.H(1), .W(1), .DEPTH(4), .BIAS(3), .DATA_WIDTH(32), .ROM_LAT(0)) dut0 (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy0), .done_o(done0),
    .rd_en_o(rd0), .in_addr_o(in0), .k_addr_o(k0), .b_addr_o(b0), .mac_clr_o(clr0),
    .mac_en_o(en0), .bias_add_o(badd0), .out_valid_o(ov0), .out_ready_i(out_ready_i),
    .out_idx_o(idx0)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ctl = {busy, rd_en, mac_en, mac_clr, bias_add, out_valid, done}
  typedef struct {
    logic       start;
    logic       ready;
    logic [6:0] ctl;
    int         in_a;
    int         k_a;
    int         idx;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic [6:0] ctl, input int ia, input int ka, input int ix);
    vec_t v;
    v.start = s;
    v.ready = 1'b1;
    v.ctl   = ctl;
    v.in_a  = ia;
    v.k_a   = ka;
    v.idx   = ix;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset state visible, rst_i released.
  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    out_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    // Full pass with ignored starts at 3 (LOAD) and 22 (DONE), accepted start at 23.
    vq.push_back(mk(1'b1, 7'b0000000, 0, 0, 0));
    vq.push_back(mk(1'b0, 7'b1100000, 0, 0, 0));
    vq.push_back(mk(1'b0, 7'b1111000, 1, 1, 0));
    vq.push_back(mk(1'b1, 7'b1110000, 2, 2, 0));
    vq.push_back(mk(1'b0, 7'b1110000, 3, 3, 0));
    vq.push_back(mk(1'b0, 7'b1010000, 3, 3, 0));
    vq.push_back(mk(1'b0, 7'b1000100, 3, 3, 0));
    vq.push_back(mk(1'b0, 7'b1000010, 3, 3, 0));
    vq.push_back(mk(1'b0, 7'b1100000, 0, 4, 1));
    vq.push_back(mk(1'b0, 7'b1111000, 1, 5, 1));
    vq.push_back(mk(1'b0, 7'b1110000, 2, 6, 1));
    vq.push_back(mk(1'b0, 7'b1110000, 3, 7, 1));
    vq.push_back(mk(1'b0, 7'b1010000, 3, 7, 1));
    vq.push_back(mk(1'b0, 7'b1000100, 3, 7, 1));
    vq.push_back(mk(1'b0, 7'b1000010, 3, 7, 1));
    vq.push_back(mk(1'b0, 7'b1100000, 0, 8, 2));
    vq.push_back(mk(1'b0, 7'b1111000, 1, 9, 2));
    vq.push_back(mk(1'b0, 7'b1110000, 2, 10, 2));
    vq.push_back(mk(1'b0, 7'b1110000, 3, 11, 2));
    vq.push_back(mk(1'b0, 7'b1010000, 3, 11, 2));
    vq.push_back(mk(1'b0, 7'b1000100, 3, 11, 2));
    vq.push_back(mk(1'b0, 7'b1000010, 3, 11, 2));
    vq.push_back(mk(1'b1, 7'b1000001, 3, 11, 2));
    vq.push_back(mk(1'b1, 7'b0000000, 3, 11, 2));
    vq.push_back(mk(1'b0, 7'b1100000, 0, 0, 0));

    do_reset();
    for (int c = 0; c < vq.size(); c++) begin
      start_i = vq[c].start;
      out_ready_i = vq[c].ready;
      @(negedge clk);
      chk($sformatf("ctl@%0d", c), int'(ctl1), int'(vq[c].ctl));
      chk($sformatf("in_addr@%0d", c), int'(in1), vq[c].in_a);
      chk($sformatf("k_addr@%0d", c), int'(k1), vq[c].k_a);
      chk($sformatf("out_idx@%0d", c), int'(idx1), vq[c].idx);
      chk($sformatf("b_addr@%0d", c), int'(b1), vq[c].idx);
      next_cycle();
    end

    // Reset for three cycles in the middle of neuron 1.
    do_reset();
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("rst_pre_mac_en", int'(en1), 1);
    rst_i = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_ctl", int'(ctl1), 0);
    chk("rst_k_addr", int'(k1), 0);
    chk("rst_in_addr", int'(in1), 0);
    chk("rst_idx", int'(idx1), 0);
    chk("rst_ctl_lat0", int'(ctl0), 0);
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_busy_after", int'(busy1), 0);

    // Backpressure: out_ready_i low during cycles 7..11.
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      start_i = (c == 0);
      out_ready_i = !(c >= 7 && c <= 11);
      @(negedge clk);
      if (c >= 7 && c <= 12) begin
        chk($sformatf("bp_valid@%0d", c), int'(ov1), 1);
        chk($sformatf("bp_idx@%0d", c), int'(idx1), 0);
        chk($sformatf("bp_rd@%0d", c), int'(rd1), 0);
      end
      if (c == 13 || c == 16) chk($sformatf("bp_load_rd@%0d", c), int'(rd1), 1);
      if (c == 13) begin
        chk("bp_k_addr@13", int'(k1), 4);
        chk("bp_idx@13", int'(idx1), 1);
      end
      if (c == 17) chk("bp_drain_rd@17", int'(rd1), 0);
      if (c >= 25 && c <= 28) chk($sformatf("bp_done@%0d", c), int'(done1), (c == 27) ? 1 : 0);
      next_cycle();
    end

    // Reset at cycle 3 (mid-LOAD), restart at cycle 6.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      start_i = (c == 0 || c == 6);
      rst_i = (c == 3);
      @(negedge clk);
      if (c == 3) chk("rl_mac_en@3", int'(en1), 1);
      if (c == 4) chk("rl_ctl@4", int'(ctl1), 0);
      if (c == 6) chk("rl_busy@6", int'(busy1), 0);
      if (c == 7) begin
        chk("rl_k_addr@7", int'(k1), 0);
        chk("rl_rd@7", int'(rd1), 1);
      end
      if (c == 8) begin
        chk("rl_clr@8", int'(clr1), 1);
        chk("rl_en@8", int'(en1), 1);
      end
      next_cycle();
    end
    rst_i = 1'b0;

    // Zero-latency build: strobes coincide with reads, no DRAIN, period 6.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      start_i = (c == 0);
      out_ready_i = 1'b1;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("l0_rd@%0d", c), int'(rd0), 1);
        chk($sformatf("l0_en@%0d", c), int'(en0), 1);
        chk($sformatf("l0_clr@%0d", c), int'(clr0), (c == 1) ? 1 : 0);
      end
      if (c == 5) chk("l0_ctl@5", int'(ctl0), 7'b1000100);
      if (c == 6 || c == 12 || c == 18) begin
        chk($sformatf("l0_valid@%0d", c), int'(ov0), 1);
        chk($sformatf("l0_idx@%0d", c), int'(idx0), (c - 6) / 6);
      end
      if (c == 18 || c == 19) chk($sformatf("l0_done@%0d", c), int'(done0), (c == 19) ? 1 : 0);
      if (c == 20) chk("l0_busy@20", int'(busy0), 0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
